// File: rtl/dmem_responder.sv
// Data-memory slave for the core's load/store port: one outstanding request,
// fixed access latency, response held until the core accepts it.
module dmem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);
    localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t        state_reg, state_next;
    logic [3:0]    cnt_reg, cnt_next;
    logic          we_reg;
    logic [31:0]   addr_reg;
    logic [31:0]   wdata_reg;
    logic [3:0]    be_reg;
    logic          err_reg;
    logic          accept;
    logic          access_fire;
    logic          access_err;
    logic [AW-1:0] word_idx;

    assign access_err = (addr_reg[1:0] != 2'b00) ||
                        ({2'b00, addr_reg[31:2]} >= 32'(DEPTH_WORDS));
    assign word_idx   = addr_reg[AW+1:2];

    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        req_ready   = 1'b0;
        resp_valid  = 1'b0;
        accept      = 1'b0;
        access_fire = 1'b0;
        case (state_reg)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    accept     = 1'b1;
                    cnt_next   = 4'(LATENCY - 1);
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (cnt_reg == 4'd0) begin
                    access_fire = 1'b1;
                    state_next  = RESP;
                end else begin
                    cnt_next = cnt_reg - 4'd1;
                end
            end
            RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            cnt_reg   <= 4'd0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            if (access_fire) begin
                err_reg <= access_err;
            end
        end
    end

    // Request fields are only consumed after the handshake, so they need no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            we_reg    <= req_we;
            addr_reg  <= req_addr;
            wdata_reg <= req_wdata;
            be_reg    <= req_be;
        end
    end

    // One byte-wide RAM per lane gives byte-enable writes without read-modify-write.
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        logic [7:0] mem [DEPTH_WORDS];
        logic [7:0] rdata_reg;

        always_ff @(posedge clk) begin
            if (!rst && access_fire && we_reg && !access_err && be_reg[gi]) begin
                mem[word_idx] <= wdata_reg[8*gi +: 8];
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                rdata_reg <= 8'h00;
            end else if (access_fire) begin
                rdata_reg <= (!we_reg && !access_err) ? mem[word_idx] : 8'h00;
            end
        end

        assign resp_rdata[8*gi +: 8] = rdata_reg;
    end

    assign resp_err = err_reg;

endmodule
